// File: rtl/data_mem_responder.sv
// Fixed-latency 16-bit word memory responder: validates each request, holds it
// for LATENCY cycles, then commits the write or registers the read data.
//
// state  | meaning
// S_IDLE | no transaction; inputs sampled for a new request
// S_BUSY | request captured; latency counter running down
// S_RESP | one-cycle response (done=1); inputs sampled for a new request
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte-address bits above the top word-index bit must be zero.
  localparam logic [15:0] HI_MASK = 16'hFFFF << (ADDR_W + 1);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx;
  logic [15:0]         r_wdata;
  logic [15:0]         w_wdata;
  logic                r_is_wr;
  logic                w_is_wr;
  logic                r_err;
  logic [15:0]         r_data_out;
  logic [15:0]         r_mem [2**ADDR_W];

  logic w_req;
  logic w_bad;
  logic w_good;
  logic w_capture;
  logic w_commit;

  assign w_req  = (r_state != S_BUSY) && (rd || wr);
  assign w_bad  = w_req && ((rd && wr) || addr[0] || ((addr & HI_MASK) != 16'h0000));
  assign w_good = w_req && !w_bad;

  // With LATENCY=1 the commit happens on the accepting edge, straight from the inputs.
  assign w_idx   = (r_state == S_BUSY) ? r_idx   : addr[ADDR_W:1];
  assign w_wdata = (r_state == S_BUSY) ? r_wdata : data_in;
  assign w_is_wr = (r_state == S_BUSY) ? r_is_wr : wr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end
      end
      default: begin
        if (w_good) begin
          w_capture = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = LAT_M1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 16'h0000;
      r_is_wr    <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_bad;
      if (w_capture) begin
        r_idx   <= addr[ADDR_W:1];
        r_wdata <= data_in;
        r_is_wr <= wr;
      end
      if (w_commit && !w_is_wr) begin
        r_data_out <= r_mem[w_idx];
      end
    end
  end

  // Storage is deliberately left out of reset; rst only blocks a commit.
  always_ff @(posedge clk) begin
    if (rst && w_commit && w_is_wr) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign stall    = rst && ((r_state == S_BUSY) || w_good);
  assign done     = (r_state == S_RESP);
  assign err      = r_err;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at LATENCY 2, 1 and 15: directed cases plus
// random traffic against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int AW = 8;

  typedef struct {
    logic        s;
    logic        d;
    logic        e;
    logic [15:0] q;
    bit          qk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int lat, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (LATENCY=%0d) at %0t: got %h expected %h", nm, lat, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int LAT    = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    localparam int RST_AT = (LAT > 1) ? 1 : 0;

    logic        rst, rd, wr;
    logic [15:0] addr, data_in, data_out;
    logic        stall, done, err;
    bit          fin = 1'b0;

    exp_t        eq[$];
    logic [15:0] mem_m [256];
    bit          vld [256];
    logic [15:0] m_dout;
    bit          m_known, m_done, m_err;
    int          run, last_run;
    logic [7:0]  pool [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd254, 8'd255};

    data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
      .data_out(data_out), .stall(stall), .done(done), .err(err)
    );

    always @(negedge clk) begin : cmp
      exp_t e;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        check("stall", LAT, {15'b0, stall}, {15'b0, e.s});
        check("done", LAT, {15'b0, done}, {15'b0, e.d});
        check("err", LAT, {15'b0, err}, {15'b0, e.e});
        if (e.qk) check("data_out", LAT, data_out, e.q);
      end
      if (done === 1'b1) last_run = run;
      if (stall === 1'b1) run++;
      else run = 0;
    end

    task automatic cycle(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input logic s);
      exp_t e;
      rd = r; wr = w; addr = a; data_in = d;
      e.s = s; e.d = m_done; e.e = m_err; e.q = m_dout; e.qk = m_known;
      eq.push_back(e);
      m_done = 1'b0;
      m_err  = 1'b0;
      @(posedge clk);
      #1;
    endtask

    task automatic idle();
      cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    function automatic bit is_bad(input logic r, input logic w, input logic [15:0] a);
      return (r && w) || a[0] || ((a >> (AW + 1)) != 16'd0);
    endfunction

    task automatic xact(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input bit garble);
      if (is_bad(r, w, a)) begin
        cycle(r, w, a, d, 1'b0);
        m_err = 1'b1;
      end else if (!(r || w)) begin
        cycle(1'b0, 1'b0, a, d, 1'b0);
      end else begin
        cycle(r, w, a, d, 1'b1);
        for (int i = 1; i < LAT; i++) begin
          if (garble) cycle(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b1);
          else        cycle(r, w, a, d, 1'b1);
        end
        if (w) begin
          mem_m[a[AW:1]] = d;
          vld[a[AW:1]]   = 1'b1;
        end else begin
          m_dout  = mem_m[a[AW:1]];
          m_known = vld[a[AW:1]];
        end
        m_done = 1'b1;
      end
    endtask

    initial begin : drv
      logic [15:0] a;
      logic        r, w;
      int          k;
      rst = 1'b0; rd = 1'b1; wr = 1'b0; addr = 16'h0010; data_in = 16'h0000;
      m_dout = 16'h0000; m_known = 1'b1; m_done = 1'b0; m_err = 1'b0;
      run = 0; last_run = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", LAT, {15'b0, stall}, 16'd0);
      check("rst_done", LAT, {15'b0, done}, 16'd0);
      check("rst_err", LAT, {15'b0, err}, 16'd0);
      check("rst_dout", LAT, data_out, 16'h0000);

      // first edge after reset release samples the request
      rst = 1'b1;
      xact(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      idle();
      check("write_stall_cycles", LAT, 16'(last_run), 16'(LAT));
      xact(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      check("read_done", LAT, {15'b0, done}, 16'd1);
      check("read_beef", LAT, data_out, 16'hBEEF);
      idle();

      xact(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
      check("odd_err", LAT, {15'b0, err}, 16'd1);
      check("odd_done", LAT, {15'b0, done}, 16'd0);
      check("odd_dout", LAT, data_out, 16'hBEEF);
      idle();
      xact(1'b1, 1'b1, 16'h0010, 16'h1111, 1'b0);
      check("rdwr_err", LAT, {15'b0, err}, 16'd1);
      idle();
      xact(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      check("mem_after_bad", LAT, data_out, 16'hBEEF);
      idle();

      xact(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0);
      check("hi_addr_err", LAT, {15'b0, err}, 16'd1);
      idle();
      xact(1'b0, 1'b1, 16'h00FE, 16'h7777, 1'b0);
      xact(1'b0, 1'b1, 16'h01FE, 16'hCAFE, 1'b0);
      xact(1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0);
      check("word255", LAT, data_out, 16'hCAFE);
      xact(1'b1, 1'b0, 16'h00FE, 16'h0000, 1'b0);
      check("word127", LAT, data_out, 16'h7777);
      idle();

      xact(1'b0, 1'b1, 16'h0004, 16'h1234, 1'b0);
      check("b2b_wr_done", LAT, {15'b0, done}, 16'd1);
      xact(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
      check("b2b_rd", LAT, data_out, 16'h1234);
      idle();

      // reset in the middle of a write must abort it
      xact(1'b0, 1'b1, 16'h0008, 16'hAAAA, 1'b0);
      idle();
      for (int i = 0; i < RST_AT; i++) cycle(1'b0, 1'b1, 16'h0008, 16'h5555, 1'b1);
      rd = 1'b0; wr = 1'b1; addr = 16'h0008; data_in = 16'h5555; rst = 1'b0;
      #1;
      check("rst_mid_stall", LAT, {15'b0, stall}, 16'd0);
      check("rst_mid_done", LAT, {15'b0, done}, 16'd0);
      check("rst_mid_err", LAT, {15'b0, err}, 16'd0);
      check("rst_mid_dout", LAT, data_out, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_done = 1'b0; m_err = 1'b0; m_dout = 16'h0000; m_known = 1'b1;
      xact(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
      check("rst_abort_keeps_old", LAT, data_out, 16'hAAAA);
      idle();

      for (int i = 0; i < 8; i++) xact(1'b0, 1'b1, {7'b0, pool[i], 1'b0}, 16'($urandom), 1'b0);
      for (int n = 0; n < 200; n++) begin
        k = $urandom_range(0, 9);
        a = {7'b0, pool[$urandom_range(0, 7)], 1'b0};
        if (k <= 3) begin
          xact(1'b0, 1'b1, a, 16'($urandom), 1'b1);
        end else if (k <= 7) begin
          xact(1'b1, 1'b0, a, 16'($urandom), 1'b1);
        end else if (k == 8) begin
          r = 1'($urandom_range(0, 1));
          w = !r;
          case ($urandom_range(0, 2))
            0:       begin r = 1'b1; w = 1'b1; end
            1:       a = a | 16'h0001;
            default: a = a | (16'h0200 << $urandom_range(0, 6));
          endcase
          xact(r, w, a, 16'($urandom), 1'b1);
          idle();
        end else begin
          idle();
        end
      end
      idle();
      idle();
      fin = 1'b1;
    end
  end

  initial begin : fin_wait
    int c;
    c = 0;
    while (!(g_lat[0].fin && g_lat[1].fin && g_lat[2].fin) && c < 60000) begin
      @(posedge clk);
      c++;
    end
    if (!(g_lat[0].fin && g_lat[1].fin && g_lat[2].fin)) begin
      total++;
      bad++;
      $display("FAIL timeout: drivers got %b%b%b expected 111", g_lat[2].fin, g_lat[1].fin, g_lat[0].fin);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
